// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module : fetch_stage_pkg
// Brief  : Shared fetch/decode constants, IF/ID layout and PC helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam int          IMEM_AW_DEFAULT  = 5;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam int IFID_W = $bits(ifid_t);

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
// ============================================================================
// Module : fetch_stage_ifid_reg
// Brief  : Pipeline register, priority reset > flush > stall > load.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage_ifid_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] FLUSH_MASK = '1,
    parameter logic [WIDTH-1:0] FLUSH_VAL  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);

    // Flush rewrites only the masked fields; the rest keep their value.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (flush) begin
            q <= (q & ~FLUSH_MASK) | (FLUSH_VAL & FLUSH_MASK);
        end else if (!stall) begin
            q <= load_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module : fetch_stage
// Brief  : MIPS instruction-fetch stage: PC, next-PC mux and IF/ID register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IMEM_AW  = IMEM_AW_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pc4,
    output logic               ifid_valid,
    output logic               misalign,
    output logic [31:0]        fetch_count
);

    localparam ifid_t IFID_RESET = '{instr: NOP_WORD, pc4: 32'd0, valid: 1'b0};
    localparam ifid_t IFID_FLUSH_MASK = '{instr: 32'hFFFF_FFFF, pc4: 32'd0, valid: 1'b1};

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    ifid_t       ifid_load;
    ifid_t       ifid_q;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];

    // Redirect beats stall so a control hazard resolves during a data stall.
    always_comb begin
        next_pc = pc_plus4;
        if (redirect) begin
            next_pc = align_word(redirect_pc);
        end else if (stall) begin
            next_pc = pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= PC_RESET;
        end else begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end

    // Counts exactly the edges on which IF/ID loads a valid instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (!flush && !stall) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign ifid_load = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};

    fetch_stage_ifid_reg #(
        .WIDTH      (IFID_W),
        .RESET_VAL  (IFID_RESET),
        .FLUSH_MASK (IFID_FLUSH_MASK),
        .FLUSH_VAL  (IFID_RESET)
    ) u_ifid_reg (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .stall     (stall),
        .load_data (ifid_load),
        .q         (ifid_q)
    );

    assign ifid_instr = ifid_q.instr;
    assign ifid_pc4   = ifid_q.pc4;
    assign ifid_valid = ifid_q.valid;

endmodule

`default_nettype wire
